// File: rtl/systolic_feed_ctrl.sv
// Fill/drain sequencer for the row delay-buffer FIFOs feeding the systolic array.
// Fills rows in order from a valid/ready load stream, then drains them with a one-row diagonal skew.

module systolic_feed_row #(
    parameter int ROW   = 0,
    parameter int DEPTH = 8,
    parameter int TW    = 4
) (
    input  logic          drain,
    input  logic [TW-1:0] t,
    output logic          act
);
    logic [31:0] t_w;

    assign t_w = 32'(t);
    // Row ROW is live for DEPTH drain cycles starting at t == ROW.
    assign act = drain && (t_w >= 32'(ROW)) && (t_w < 32'(ROW + DEPTH));
endmodule

module systolic_feed_ctrl #(
    parameter int DIM   = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    output logic [$clog2(DIM)-1:0] ld_row,
    output logic                   fill_mode,
    output logic [DIM-1:0]         fifo_en,
    output logic [DIM-1:0]         row_valid,
    output logic                   busy,
    output logic                   done
);
    localparam int RW = $clog2(DIM);
    localparam int EW = $clog2(DEPTH);
    localparam int TW = $clog2(DIM + DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [EW-1:0] elem_q, elem_d;
    logic [TW-1:0] t_q, t_d;
    logic [DIM-1:0] drain_act;
    logic          in_drain;

    assign in_drain = (state_q == S_DRAIN);

    for (genvar r = 0; r < DIM; r++) begin : g_row
        systolic_feed_row #(.ROW(r), .DEPTH(DEPTH), .TW(TW)) u_row (
            .drain (in_drain),
            .t     (t_q),
            .act   (drain_act[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            elem_q  <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            elem_q  <= elem_d;
            t_q     <= t_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        elem_d  = elem_q;
        t_d     = t_q;
        if (abort) begin
            state_d = S_IDLE;
            row_d   = '0;
            elem_d  = '0;
            t_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) state_d = S_FILL;
                S_FILL: begin
                    // ld_ready is constant 1 in FILL, so every ld_valid is an accept.
                    if (ld_valid) begin
                        if (elem_q == EW'(DEPTH - 1)) begin
                            elem_d = '0;
                            if (row_q == RW'(DIM - 1)) begin
                                row_d   = '0;
                                t_d     = '0;
                                state_d = S_DRAIN;
                            end else begin
                                row_d = row_q + RW'(1);
                            end
                        end else begin
                            elem_d = elem_q + EW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (t_q == TW'(DIM + DEPTH - 2)) begin
                        t_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ld_ready  = 1'b0;
        ld_row    = '0;
        fill_mode = 1'b0;
        fifo_en   = '0;
        row_valid = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_FILL: begin
                ld_ready  = 1'b1;
                fill_mode = 1'b1;
                ld_row    = row_q;
                busy      = 1'b1;
                for (int r = 0; r < DIM; r++)
                    fifo_en[r] = ld_valid && (row_q == RW'(r));
            end
            S_DRAIN: begin
                busy      = 1'b1;
                fifo_en   = drain_act;
                row_valid = drain_act;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomized bench for systolic_feed_ctrl: pass-level reference model plus a FIFO data model.
// A second instance at DIM=3, DEPTH=5 covers non-power-of-two timing.

module tb_systolic_feed_ctrl;
    localparam int DIM   = 8;
    localparam int DEPTH = 8;

    logic           clk, rst_n, start, abort, ld_valid;
    logic           ld_ready, fill_mode, busy, done;
    logic [2:0]     ld_row;
    logic [DIM-1:0] fifo_en, row_valid;

    logic       s_start, s_abort, s_ld_valid;
    logic       s_ld_ready, s_fill_mode, s_busy, s_done;
    logic [1:0] s_ld_row;
    logic [2:0] s_fifo_en, s_row_valid;

    int n_cmp = 0;
    int n_bad = 0;

    systolic_feed_ctrl #(.DIM(DIM), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_row(ld_row), .fill_mode(fill_mode), .fifo_en(fifo_en),
        .row_valid(row_valid), .busy(busy), .done(done)
    );

    systolic_feed_ctrl #(.DIM(3), .DEPTH(5)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .ld_valid(s_ld_valid),
        .ld_ready(s_ld_ready), .ld_row(s_ld_row), .fill_mode(s_fill_mode), .fifo_en(s_fifo_en),
        .row_valid(s_row_valid), .busy(s_busy), .done(s_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: phase (0 idle, 1 fill, 2 drain, 3 done), words accepted n, drain step t.
    int ph, n, t;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 0; n <= 0; t <= 0;
        end else if (abort) begin
            ph <= 0; n <= 0; t <= 0;
        end else begin
            case (ph)
                0: if (start) ph <= 1;
                1: if (ld_valid) begin
                    if (n == DIM*DEPTH - 1) begin ph <= 2; n <= 0; t <= 0; end
                    else n <= n + 1;
                end
                2: if (t == DIM + DEPTH - 2) ph <= 3; else t <= t + 1;
                default: ph <= 0;
            endcase
        end
    end

    // Datapath stand-in: word index n on the load bus, zero while draining.
    int fifo [DIM][DEPTH];
    int en_cnt [DIM];
    initial begin
        for (int r = 0; r < DIM; r++) begin
            en_cnt[r] = 0;
            for (int i = 0; i < DEPTH; i++) fifo[r][i] = 0;
        end
    end
    always @(posedge clk) begin
        for (int r = 0; r < DIM; r++) begin
            if (fifo_en[r]) begin
                for (int i = 0; i < DEPTH-1; i++) fifo[r][i] <= fifo[r][i+1];
                fifo[r][DEPTH-1] <= fill_mode ? n : 0;
                en_cnt[r] <= en_cnt[r] + 1;
            end
        end
    end

    function automatic logic [DIM-1:0] skew_mask(input int tt);
        logic [DIM-1:0] m = '0;
        for (int r = 0; r < DIM; r++) m[r] = (tt >= r) && (tt < r + DEPTH);
        return m;
    endfunction

    function automatic logic [DIM-1:0] exp_en(input int p, input int nn, input int tt, input logic v);
        logic [DIM-1:0] m = '0;
        if (p == 1 && v) m[nn / DEPTH] = 1'b1;
        else if (p == 2) m = skew_mask(tt);
        return m;
    endfunction

    function automatic logic fifos_zero();
        logic z = 1'b1;
        for (int r = 0; r < DIM; r++)
            for (int i = 0; i < DEPTH; i++) if (fifo[r][i] != 0) z = 1'b0;
        return z;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ctrl", {ld_ready, fill_mode, busy, done}, {ph == 1, ph == 1, ph != 0, ph == 3});
            chk("fifo_en", fifo_en, exp_en(ph, n, t, ld_valid));
            chk("row_valid", row_valid, (ph == 2) ? skew_mask(t) : '0);
            if (ph == 1) chk("ld_row", ld_row, n / DEPTH);
            if (ph == 0) chk("idle_row", ld_row, 0);
            if (ph == 2)
                for (int r = 0; r < DIM; r++)
                    if (t >= r && t < r + DEPTH) chk("q", fifo[r][0], r*DEPTH + t - r);
            if (ph == 3) chk("drained", fifos_zero(), 1);
        end
    end

    // Caller sits just after a rising edge; start is sampled on the next one (cycle 0).
    task automatic run_pass(input int stall_pct, input string tag);
        int c0 [DIM];
        int stalls = 0;
        int cyc = -1;
        for (int r = 0; r < DIM; r++) c0[r] = en_cnt[r];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 400; k++) begin
            ld_valid = ($urandom_range(0, 99) >= stall_pct);
            @(negedge clk);
            if (fill_mode && !ld_valid) stalls++;
            if (done) begin cyc = k; break; end
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        chk(tag, cyc, 80 + stalls);
        for (int r = 0; r < DIM; r++) chk("row_enables", en_cnt[r] - c0[r], DEPTH + (DIM + DEPTH - 1 >= r + DEPTH ? DEPTH : 0));
        @(posedge clk); #1;
    endtask

    task automatic wait_for(input int wph, input int wn, input int wt, input string tag);
        logic ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(posedge clk); #1;
            ok = (ph == wph) && (wph != 1 || n == wn) && (wph != 2 || t == wt);
        end
        chk(tag, ok, 1);
    endtask

    initial begin
        int d1, d2, fillc, drainc, first2, last2, sd;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ld_valid = 1'b0;
        s_start = 1'b0; s_abort = 1'b0; s_ld_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {ld_ready, ld_row, fill_mode, fifo_en, row_valid, busy, done}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_pass(0, "pass_len_full");
        run_pass(50, "pass_len_stall");
        run_pass(30, "pass_len_stall2");

        // Abort at row 3 element 5, then at drain t=6; neither may produce done.
        ld_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_for(1, 3*DEPTH + 5, 0, "reach_r3e5");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_fill_busy", busy, 0);
        chk("abort_fill_done", done, 0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_for(2, 0, 6, "reach_t6");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_drain_busy", busy, 0);
        chk("abort_drain_rv", row_valid, 0);
        @(posedge clk); #1;
        run_pass(0, "pass_after_abort");

        // start held high: done at 80, one IDLE cycle at 81, next done at 161.
        d1 = -1; d2 = -1;
        start = 1'b1; ld_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (k == 81) chk("held_gap_idle", busy, 0);
            if (k == 82) chk("held_refill", busy, 1);
            if (done && d1 < 0) d1 = k;
            else if (done) begin d2 = k; break; end
            @(posedge clk); #1;
        end
        start = 1'b0; ld_valid = 1'b0;
        chk("held_done1", d1, 80);
        chk("held_done2", d2, 161);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Asynchronous reset mid-drain.
        start = 1'b1; ld_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_for(2, 0, 4, "reach_t4");
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outs", {ld_ready, ld_row, fill_mode, fifo_en, row_valid, busy, done}, 0);
        ld_valid = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_pass(0, "pass_after_rst");

        // Small instance: FILL 15, DRAIN 7 (cycles 16..22), row 2 live at t=2..6, done at 23.
        fillc = 0; drainc = 0; first2 = -1; last2 = -1; sd = -1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int k = 1; k < 60; k++) begin
            @(negedge clk);
            if (s_fill_mode) fillc++;
            if (s_busy && !s_fill_mode && !s_done) drainc++;
            if (s_row_valid[2]) begin
                if (first2 < 0) first2 = k;
                last2 = k;
            end
            if (s_done) begin sd = k; break; end
            @(posedge clk); #1;
        end
        chk("small_fill", fillc, 15);
        chk("small_drain", drainc, 7);
        chk("small_rv2_first", first2, 18);
        chk("small_rv2_last", last2, 22);
        chk("small_done", sd, 23);
        @(posedge clk); #1;
        @(negedge clk);
        chk("small_idle", {s_busy, s_done, s_ld_ready}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
